// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver sequencing a 16x16 single-bit maze memory: marks
// visited cells, keeps the path on a direction stack, then replays it.
module maze_solver_ctrl #(
   parameter logic [3:0] START_X = 4'd0,
   parameter logic [3:0] START_Y = 4'd0,
   parameter logic [3:0] GOAL_X  = 4'd15,
   parameter logic [3:0] GOAL_Y  = 4'd15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mem_dout,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [3:0] mem_x,
   output logic [3:0] mem_y,
   output logic       mem_din,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic       path_valid,
   output logic [1:0] path_dir,
   output logic       path_last,
   output logic [3:0] cur_x,
   output logic [3:0] cur_y
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_RD_START  = 4'd1,
      S_CHK_START = 4'd2,
      S_TRY       = 4'd3,
      S_RD_NB     = 4'd4,
      S_CHK_NB    = 4'd5,
      S_MOVE      = 4'd6,
      S_BACK      = 4'd7,
      S_REPLAY    = 4'd8,
      S_DONE      = 4'd9,
      S_FAIL      = 4'd10
   } state_t;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_DOWN  = 2'd3;

   state_t     state_r, state_nxt_s;
   logic [8:0] sp_r, sp_nxt_s;
   logic [8:0] rp_r, rp_nxt_s;
   logic [2:0] try_dir_r, try_dir_nxt_s;
   logic [3:0] cur_x_r, cur_y_r, cur_x_nxt_s, cur_y_nxt_s;
   logic [3:0] mem_x_r, mem_y_r, mem_x_nxt_s, mem_y_nxt_s;
   logic       mem_rd_r, mem_wr_r, mem_din_r;
   logic       mem_rd_nxt_s, mem_wr_nxt_s;
   logic       busy_r, done_r, fail_r;
   logic       busy_nxt_s, done_nxt_s, fail_nxt_s;
   logic       path_valid_r, path_valid_nxt_s;
   logic [1:0] path_dir_r, path_dir_nxt_s;
   logic       path_last_r, path_last_nxt_s;
   logic       push_s;
   logic [1:0] stack_r [0:255];
   logic [7:0] top_idx_s;
   logic [1:0] top_dir_s;
   logic [1:0] replay_dir_s;
   logic [3:0] nb_x_s, nb_y_s;
   logic       nb_ok_s;

   assign top_idx_s    = sp_r[7:0] - 8'd1;
   assign top_dir_s    = stack_r[top_idx_s];
   assign replay_dir_s = stack_r[rp_r[7:0]];

   // Neighbour of the current cell in the direction being tried, with edge check.
   always_comb begin
      nb_x_s  = cur_x_r;
      nb_y_s  = cur_y_r;
      nb_ok_s = 1'b0;
      case (try_dir_r[1:0])
         DIR_UP: begin
            nb_ok_s = (cur_y_r != 4'd0);
            nb_y_s  = cur_y_r - 4'd1;
         end
         DIR_RIGHT: begin
            nb_ok_s = (cur_x_r != 4'd15);
            nb_x_s  = cur_x_r + 4'd1;
         end
         DIR_LEFT: begin
            nb_ok_s = (cur_x_r != 4'd0);
            nb_x_s  = cur_x_r - 4'd1;
         end
         DIR_DOWN: begin
            nb_ok_s = (cur_y_r != 4'd15);
            nb_y_s  = cur_y_r + 4'd1;
         end
         default: nb_ok_s = 1'b0;
      endcase
   end

   // Next-state and next-output logic; strobes and flags are registered from these.
   always_comb begin
      state_nxt_s      = state_r;
      sp_nxt_s         = sp_r;
      rp_nxt_s         = rp_r;
      try_dir_nxt_s    = try_dir_r;
      cur_x_nxt_s      = cur_x_r;
      cur_y_nxt_s      = cur_y_r;
      mem_x_nxt_s      = mem_x_r;
      mem_y_nxt_s      = mem_y_r;
      mem_wr_nxt_s     = 1'b0;
      path_valid_nxt_s = 1'b0;
      path_dir_nxt_s   = 2'd0;
      path_last_nxt_s  = 1'b0;
      push_s           = 1'b0;
      case (state_r)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_nxt_s = S_RD_START;
               sp_nxt_s    = 9'd0;
               cur_x_nxt_s = START_X;
               cur_y_nxt_s = START_Y;
               mem_x_nxt_s = START_X;
               mem_y_nxt_s = START_Y;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_RD_START: state_nxt_s = S_CHK_START;
         S_CHK_START: begin
            if (mem_dout) begin
               state_nxt_s = S_FAIL;
            end else begin
               mem_wr_nxt_s  = 1'b1;
               try_dir_nxt_s = 3'd0;
               rp_nxt_s      = 9'd0;
               if ((START_X == GOAL_X) && (START_Y == GOAL_Y)) begin
                  state_nxt_s = S_REPLAY;
               end else begin
                  state_nxt_s = S_TRY;
               end
            end
         end
         S_TRY: begin
            if (try_dir_r[2]) begin
               state_nxt_s = S_BACK;
            end else if (!nb_ok_s) begin
               try_dir_nxt_s = try_dir_r + 3'd1;
            end else begin
               mem_x_nxt_s = nb_x_s;
               mem_y_nxt_s = nb_y_s;
               state_nxt_s = S_RD_NB;
            end
         end
         S_RD_NB: state_nxt_s = S_CHK_NB;
         S_CHK_NB: begin
            if (mem_dout) begin
               try_dir_nxt_s = try_dir_r + 3'd1;
               state_nxt_s   = S_TRY;
            end else begin
               mem_wr_nxt_s = 1'b1;
               state_nxt_s  = S_MOVE;
            end
         end
         S_MOVE: begin
            // mem_x/mem_y still hold the neighbour that was just read and marked
            push_s        = 1'b1;
            sp_nxt_s      = sp_r + 9'd1;
            cur_x_nxt_s   = mem_x_r;
            cur_y_nxt_s   = mem_y_r;
            try_dir_nxt_s = 3'd0;
            rp_nxt_s      = 9'd0;
            if ((mem_x_r == GOAL_X) && (mem_y_r == GOAL_Y)) begin
               state_nxt_s = S_REPLAY;
            end else begin
               state_nxt_s = S_TRY;
            end
         end
         S_BACK: begin
            if (sp_r == 9'd0) begin
               state_nxt_s = S_FAIL;
            end else begin
               sp_nxt_s      = sp_r - 9'd1;
               try_dir_nxt_s = {1'b0, top_dir_s} + 3'd1;
               state_nxt_s   = S_TRY;
               case (top_dir_s)
                  DIR_UP:    cur_y_nxt_s = cur_y_r + 4'd1;
                  DIR_RIGHT: cur_x_nxt_s = cur_x_r - 4'd1;
                  DIR_LEFT:  cur_x_nxt_s = cur_x_r + 4'd1;
                  DIR_DOWN:  cur_y_nxt_s = cur_y_r - 4'd1;
                  default:   cur_x_nxt_s = cur_x_r;
               endcase
            end
         end
         S_REPLAY: begin
            if (rp_r == sp_r) begin
               state_nxt_s = S_DONE;
            end else begin
               path_valid_nxt_s = 1'b1;
               path_dir_nxt_s   = replay_dir_s;
               path_last_nxt_s  = ((rp_r + 9'd1) == sp_r);
               rp_nxt_s         = rp_r + 9'd1;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
      mem_rd_nxt_s = (state_nxt_s == S_RD_START) || (state_nxt_s == S_RD_NB);
      busy_nxt_s   = (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE) &&
                     (state_nxt_s != S_FAIL);
      done_nxt_s   = (state_nxt_s == S_DONE);
      fail_nxt_s   = (state_nxt_s == S_FAIL);
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_IDLE;
         sp_r         <= 9'd0;
         rp_r         <= 9'd0;
         try_dir_r    <= 3'd0;
         cur_x_r      <= START_X;
         cur_y_r      <= START_Y;
         mem_x_r      <= 4'd0;
         mem_y_r      <= 4'd0;
         mem_rd_r     <= 1'b0;
         mem_wr_r     <= 1'b0;
         mem_din_r    <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         fail_r       <= 1'b0;
         path_valid_r <= 1'b0;
         path_dir_r   <= 2'd0;
         path_last_r  <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         sp_r         <= sp_nxt_s;
         rp_r         <= rp_nxt_s;
         try_dir_r    <= try_dir_nxt_s;
         cur_x_r      <= cur_x_nxt_s;
         cur_y_r      <= cur_y_nxt_s;
         mem_x_r      <= mem_x_nxt_s;
         mem_y_r      <= mem_y_nxt_s;
         mem_rd_r     <= mem_rd_nxt_s;
         mem_wr_r     <= mem_wr_nxt_s;
         mem_din_r    <= mem_wr_nxt_s;
         busy_r       <= busy_nxt_s;
         done_r       <= done_nxt_s;
         fail_r       <= fail_nxt_s;
         path_valid_r <= path_valid_nxt_s;
         path_dir_r   <= path_dir_nxt_s;
         path_last_r  <= path_last_nxt_s;
      end
   end

   // Direction stack storage; contents are only meaningful below sp.
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_r[sp_r[7:0]] <= try_dir_r[1:0];
      end else begin
         stack_r[sp_r[7:0]] <= stack_r[sp_r[7:0]];
      end
   end

   assign mem_rd     = mem_rd_r;
   assign mem_wr     = mem_wr_r;
   assign mem_x      = mem_x_r;
   assign mem_y      = mem_y_r;
   assign mem_din    = mem_din_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign fail       = fail_r;
   assign path_valid = path_valid_r;
   assign path_dir   = path_dir_r;
   assign path_last  = path_last_r;
   assign cur_x      = cur_x_r;
   assign cur_y      = cur_y_r;

endmodule
